// File: rtl/mel_log_compressor.sv
// Serialises a vector of mel filterbank energies and converts each one to unsigned Q5.FRAC_BITS log2.
// Define MEL_LOG_LUT_CORRECTION_EN to add a 16-entry mantissa correction on top of the linear approximation.
module mel_log_compressor #(
  parameter  int NUM_FILTERS = 20,
  parameter  int FRAC_BITS   = 11,
  localparam int OUT_WIDTH   = 5 + FRAC_BITS,
  localparam int IDX_W       = $clog2(NUM_FILTERS)
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [32*NUM_FILTERS-1:0]   filtered_data_in,
  input  logic                        filtered_valid_in,
  output logic                        filtered_ready_out,
  output logic [OUT_WIDTH-1:0]        log_data_out,
  output logic [IDX_W-1:0]            log_index_out,
  output logic                        log_valid_out,
  output logic                        log_last_out,
  input  logic                        log_ready_in
);

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [31:0]            buffer [NUM_FILTERS];
  logic [IDX_W-1:0]       idx;
  logic                   accept;
  logic                   last_idx;

  logic                   ready_d;
  logic                   valid_d;
  logic                   last_d;
  logic [OUT_WIDTH-1:0]   data_d;
  logic [IDX_W-1:0]       index_d;
  logic [IDX_W-1:0]       idx_d;

  logic [31:0]            cur_word;
  logic [4:0]             msb_pos;
  logic [31:0]            mant;
  logic [FRAC_BITS-1:0]   frac;
  logic [OUT_WIDTH-1:0]   raw_log;
  logic [OUT_WIDTH-1:0]   log_result;

  assign accept   = filtered_valid_in && filtered_ready_out;
  assign last_idx = (idx == IDX_W'(NUM_FILTERS - 1));
  assign cur_word = buffer[idx];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    state_next = EMIT;
      EMIT:    if (log_valid_out && log_ready_in) state_next = last_idx ? IDLE : CALC;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_d = (state_next == IDLE);
    valid_d = log_valid_out;
    last_d  = log_last_out;
    data_d  = log_data_out;
    index_d = log_index_out;
    idx_d   = idx;
    case (state)
      IDLE: if (accept) idx_d = '0;
      CALC: begin
        data_d  = log_result;
        index_d = idx;
        last_d  = last_idx;
        valid_d = 1'b1;
      end
      EMIT: if (log_valid_out && log_ready_in) begin
        valid_d = 1'b0;
        if (!last_idx) idx_d = idx + IDX_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      filtered_ready_out <= 1'b1;
      log_valid_out      <= 1'b0;
      log_last_out       <= 1'b0;
      log_data_out       <= '0;
      log_index_out      <= '0;
      idx                <= '0;
    end else begin
      filtered_ready_out <= ready_d;
      log_valid_out      <= valid_d;
      log_last_out       <= last_d;
      log_data_out       <= data_d;
      log_index_out      <= index_d;
      idx                <= idx_d;
    end
  end

  // Capture buffer carries no reset; it is only read after a handshake has filled it.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      for (int i = 0; i < NUM_FILTERS; i++) buffer[i] <= filtered_data_in[i*32 +: 32];
    end
  end

  always_comb begin
    msb_pos = '0;
    for (int i = 0; i < 32; i++) if (cur_word[i]) msb_pos = 5'(i);
  end

  // Normalise so the leading one sits at bit 31; the bits below it are the linear mantissa.
  assign mant    = cur_word << (5'd31 - msb_pos);
  assign frac    = FRAC_BITS'(mant >> (31 - FRAC_BITS));
  assign raw_log = {msb_pos, frac};

`ifdef MEL_LOG_LUT_CORRECTION_EN
  localparam int LUT_SHL = (FRAC_BITS >= 11) ? FRAC_BITS - 11 : 0;
  localparam int LUT_SHR = (FRAC_BITS >= 11) ? 0 : 11 - FRAC_BITS;

  logic [OUT_WIDTH-1:0] corr;
  logic [OUT_WIDTH:0]   corr_sum;

  // Mid-bin value of log2(1+m) - m, scaled by 2^11.
  function automatic logic [7:0] lut_q11(input logic [3:0] j);
    case (j)
      4'd0:  lut_q11 = 8'd27;
      4'd1:  lut_q11 = 8'd73;
      4'd2:  lut_q11 = 8'd109;
      4'd3:  lut_q11 = 8'd137;
      4'd4:  lut_q11 = 8'd156;
      4'd5:  lut_q11 = 8'd169;
      4'd6:  lut_q11 = 8'd175;
      4'd7:  lut_q11 = 8'd176;
      4'd8:  lut_q11 = 8'd171;
      4'd9:  lut_q11 = 8'd161;
      4'd10: lut_q11 = 8'd147;
      4'd11: lut_q11 = 8'd128;
      4'd12: lut_q11 = 8'd106;
      4'd13: lut_q11 = 8'd80;
      4'd14: lut_q11 = 8'd50;
      default: lut_q11 = 8'd17;
    endcase
  endfunction

  assign corr     = (OUT_WIDTH'(lut_q11(raw_log[FRAC_BITS-1 -: 4])) << LUT_SHL) >> LUT_SHR;
  assign corr_sum = {1'b0, raw_log} + {1'b0, corr};

  always_comb begin
    if (msb_pos == 5'd0)       log_result = raw_log;
    else if (corr_sum[OUT_WIDTH]) log_result = '1;
    else                       log_result = corr_sum[OUT_WIDTH-1:0];
  end
`else
  assign log_result = raw_log;
`endif

endmodule

// File: tb/tb_mel_log_compressor.sv
// Scoreboard bench for mel_log_compressor with four filters: vector table, backpressure,
// input flow control and mid-frame reset sequences.
module tb_mel_log_compressor;

  localparam int NF = 4;
  localparam int OW = 16;
  localparam int IW = 2;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic [NF*32-1:0] filtered_data_in;
  logic            filtered_valid_in;
  logic            filtered_ready_out;
  logic [OW-1:0]   log_data_out;
  logic [IW-1:0]   log_index_out;
  logic            log_valid_out;
  logic            log_last_out;
  logic            log_ready_in;

  typedef struct packed {
    logic [127:0] words;
    logic [63:0]  results;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  index;
    logic        last;
  } out_t;

  vec_t vecs[4];
  out_t sb_q[$];
  int   vec_count   = 0;
  int   miscompares = 0;

  mel_log_compressor #(.NUM_FILTERS(NF)) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .filtered_data_in   (filtered_data_in),
    .filtered_valid_in  (filtered_valid_in),
    .filtered_ready_out (filtered_ready_out),
    .log_data_out       (log_data_out),
    .log_index_out      (log_index_out),
    .log_valid_out      (log_valid_out),
    .log_last_out       (log_last_out),
    .log_ready_in       (log_ready_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    vec_count++;
    miscompares++;
    $display("[TB] FAIL %s: timed out waiting for the DUT, got no event, required one", name);
  endtask

  // Table holds linear-approximation results; the correction is layered on when enabled.
  function automatic logic [15:0] expectedLog(input logic [31:0] x, input logic [15:0] base);
    logic [15:0] adj;
    if (x < 32'd2) return 16'h0000;
    adj = base;
`ifdef MEL_LOG_LUT_CORRECTION_EN
    begin
      real t;
      real e;
      int  c;
      int  s;
      t = ($itor(int'(base[10:7])) + 0.5) / 16.0;
      e = $ln(1.0 + t) / $ln(2.0) - t;
      c = $rtoi(e * 2048.0 + 0.5);
      s = int'(base) + c;
      adj = (s > 65535) ? 16'hFFFF : 16'(s);
    end
`endif
    return adj;
  endfunction

  task automatic pushFrame(input vec_t v);
    out_t e;
    for (int i = 0; i < NF; i++) begin
      e.data  = expectedLog(v.words[i*32 +: 32], v.results[i*16 +: 16]);
      e.index = 2'(i);
      e.last  = (i == NF - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    bit ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (filtered_ready_out) begin
        ok = 1'b1;
        break;
      end
      waitCycle();
    end
    if (!ok) begin
      timeoutFail("input_ready");
      return;
    end
    pushFrame(v);
    filtered_data_in  = v.words;
    filtered_valid_in = 1'b1;
    waitCycle();
    filtered_valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 200; c++) begin
      if (sb_q.size() == 0) break;
      waitCycle();
    end
    if (sb_q.size() != 0) timeoutFail("drain");
    repeat (4) waitCycle();
  endtask

  initial begin
    logic [18:0] held;
    bit          found;

    vecs[0].words   = {32'h0001_0000, 32'd3, 32'd2, 32'd1};
    vecs[0].results = {16'h8000, 16'h0C00, 16'h0800, 16'h0000};
    vecs[1].words   = {32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    vecs[1].results = {16'h1200, 16'hF800, 16'hFFFF, 16'h0000};
    vecs[2].words   = {32'h0000_1001, 32'h0000_0800, 32'h1234_5678, 32'h0000_0FFF};
    vecs[2].results = {16'h6000, 16'h5800, 16'hE11A, 16'h5FFF};
    vecs[3].words   = {32'h7FFF_FFFF, 32'h0000_0040, 32'h00FF_0000, 32'd7};
    vecs[3].results = {16'hF7FF, 16'h3000, 16'hBFF0, 16'h1600};

    rst_n_in          = 1'b0;
    filtered_valid_in = 1'b0;
    filtered_data_in  = '0;
    log_ready_in      = 1'b1;

    fork
      begin : monitor
        out_t e;
        forever begin
          @(negedge clk_in);
          if (rst_n_in && log_valid_out && log_ready_in) begin
            if (sb_q.size() == 0) begin
              vec_count++;
              miscompares++;
              $display("[TB] FAIL unexpected_output: got index %0d data 0x%0h, expected no output",
                       log_index_out, log_data_out);
            end else begin
              e = sb_q.pop_front();
              checkOutput("log_data",  32'(log_data_out),  32'(e.data));
              checkOutput("log_index", 32'(log_index_out), 32'(e.index));
              checkOutput("log_last",  32'(log_last_out),  32'(e.last));
            end
          end
        end
      end
    join_none

    #12;
    checkOutput("reset_ready", 32'(filtered_ready_out), 32'd1);
    checkOutput("reset_valid", 32'(log_valid_out), 32'd0);
    checkOutput("reset_last",  32'(log_last_out),  32'd0);
    checkOutput("reset_data",  32'(log_data_out),  32'd0);
    checkOutput("reset_index", 32'(log_index_out), 32'd0);
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    waitCycle();

    $display("[TB] basic conversion and latency");
    applyStimulus(vecs[0]);
    checkOutput("latency_valid_edge1", 32'(log_valid_out), 32'd0);
    waitCycle();
    checkOutput("latency_valid_edge2", 32'(log_valid_out), 32'd1);
    checkOutput("latency_first_index", 32'(log_index_out), 32'd0);
    drain();

    $display("[TB] table vectors");
    for (int v = 1; v < 4; v++) begin
      applyStimulus(vecs[v]);
      drain();
    end

    $display("[TB] backpressure on index 1");
    applyStimulus(vecs[0]);
    waitCycle();
    waitCycle();
    log_ready_in = 1'b0;
    waitCycle();
    checkOutput("bp_valid_idx1", {31'd0, log_valid_out}, 32'd1);
    checkOutput("bp_index_idx1", 32'(log_index_out), 32'd1);
    held = {log_data_out, log_index_out, log_last_out};
    for (int k = 0; k < 6; k++) begin
      waitCycle();
      checkOutput("bp_hold", {12'd0, log_valid_out, log_data_out, log_index_out, log_last_out},
                  {12'd0, 1'b1, held});
    end
    log_ready_in = 1'b1;
    waitCycle();
    checkOutput("bp_release_gap", 32'(log_valid_out), 32'd0);
    waitCycle();
    checkOutput("bp_next_valid", 32'(log_valid_out), 32'd1);
    checkOutput("bp_next_index", 32'(log_index_out), 32'd2);
    drain();

    $display("[TB] input flow control");
    pushFrame(vecs[1]);
    pushFrame(vecs[2]);
    filtered_data_in  = vecs[1].words;
    filtered_valid_in = 1'b1;
    waitCycle();
    filtered_data_in = vecs[2].words;
    for (int k = 1; k <= 8; k++) begin
      waitCycle();
      checkOutput("flow_ready", 32'(filtered_ready_out), (k == 8) ? 32'd1 : 32'd0);
    end
    waitCycle();
    checkOutput("flow_second_accepted", 32'(filtered_ready_out), 32'd0);
    filtered_valid_in = 1'b0;
    drain();

    $display("[TB] reset mid-frame");
    applyStimulus(vecs[3]);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (log_valid_out && log_index_out == 2'd2) begin
        found = 1'b1;
        break;
      end
      waitCycle();
    end
    if (!found) timeoutFail("reach_index2");
    #1 rst_n_in = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(log_valid_out), 32'd0);
    checkOutput("async_rst_last",  32'(log_last_out),  32'd0);
    checkOutput("async_rst_data",  32'(log_data_out),  32'd0);
    checkOutput("async_rst_index", 32'(log_index_out), 32'd0);
    checkOutput("async_rst_ready", 32'(filtered_ready_out), 32'd1);
    sb_q.delete();
    waitCycle();
    waitCycle();
    #2 rst_n_in = 1'b1;
    waitCycle();
    checkOutput("post_reset_ready", 32'(filtered_ready_out), 32'd1);
    applyStimulus(vecs[0]);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
